// File: rtl/ucsbece154b_icache_pkg.sv
// Shared constants for the instruction cache: FSM state encodings and the
// default cache geometry.
package ucsbece154b_icache_pkg;

    // Refill FSM encodings
    localparam logic [1:0] IC_IDLE = 2'd0;
    localparam logic [1:0] IC_REQ  = 2'd1;
    localparam logic [1:0] IC_WAIT = 2'd2;

    // Default geometry: 8 lines of 4 words
    localparam int IC_NUM_SETS        = 8;
    localparam int IC_WORDS_PER_BLOCK = 4;

endpackage

// File: rtl/ucsbece154b_icache.sv
// Direct-mapped, read-only instruction cache in front of the fetch stage.
// Hits are answered combinationally; a miss stalls fetch (Busy_o) while one
// block is refilled from memory over a single-request, multi-beat bus.
module ucsbece154b_icache
    import ucsbece154b_icache_pkg::*;
#(
    parameter int NUM_SETS        = IC_NUM_SETS,
    parameter int WORDS_PER_BLOCK = IC_WORDS_PER_BLOCK
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ReadEnable_i,
    input  logic [31:0] ReadAddress_i,
    output logic [31:0] Instruction_o,
    output logic        Ready_o,
    output logic        Busy_o,
    output logic        MemReadRequest_o,
    output logic [31:0] MemReadAddress_o,
    input  logic        MemDataReady_i,
    input  logic [31:0] MemDataIn_i
);

    localparam int WORD_BITS = $clog2(WORDS_PER_BLOCK);
    localparam int OFF       = WORD_BITS + 2;
    localparam int IDX       = $clog2(NUM_SETS);
    localparam int TAG       = 32 - IDX - OFF;

    localparam logic [WORD_BITS-1:0] LAST_BEAT = WORD_BITS'(WORDS_PER_BLOCK - 1);
    localparam logic [WORD_BITS-1:0] BEAT_ONE  = WORD_BITS'(1);

    // Arrays: only the valid bits are reset; tags and data are qualified by them
    logic [NUM_SETS-1:0] validArr;
    logic [TAG-1:0]      tagArr  [NUM_SETS];
    logic [31:0]         dataArr [NUM_SETS][WORDS_PER_BLOCK];

    logic [1:0]           state;
    logic [WORD_BITS-1:0] beatCnt;

    // Block being refilled, captured on the miss so a redirect cannot disturb it
    logic [TAG-1:0] fillTag;
    logic [IDX-1:0] fillIdx;

    logic [TAG-1:0]       addrTag;
    logic [IDX-1:0]       addrIdx;
    logic [WORD_BITS-1:0] addrWord;
    logic                 hit;
    logic                 isIdle;
    logic                 missIdle;
    logic                 beatWrite;
    logic                 lastBeat;
    logic                 unusedAddrBits;

    assign addrTag  = ReadAddress_i[31 -: TAG];
    assign addrIdx  = ReadAddress_i[OFF +: IDX];
    assign addrWord = ReadAddress_i[2 +: WORD_BITS];

    // Byte offset within the word is irrelevant for word fetches
    assign unusedAddrBits = ^ReadAddress_i[1:0];

    assign hit       = validArr[addrIdx] && (tagArr[addrIdx] == addrTag);
    assign isIdle    = (state == IC_IDLE);
    assign missIdle  = isIdle && ReadEnable_i && !hit;
    assign beatWrite = (state == IC_WAIT) && MemDataReady_i;
    assign lastBeat  = (beatCnt == LAST_BEAT);

    // Hits are only reported from IDLE; everything else stalls fetch
    assign Ready_o          = isIdle && ReadEnable_i && hit;
    assign Busy_o           = !isIdle || missIdle;
    assign Instruction_o    = Ready_o ? dataArr[addrIdx][addrWord] : 32'b0;
    assign MemReadRequest_o = (state == IC_REQ);
    assign MemReadAddress_o = MemReadRequest_o ? {fillTag, fillIdx, {OFF{1'b0}}} : 32'b0;

    // Refill FSM, beat counter and valid bits
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IC_IDLE;
            beatCnt  <= '0;
            validArr <= '0;
        end else begin
            case (state)
                IC_IDLE: begin
                    if (missIdle) begin
                        state <= IC_REQ;
                    end
                end
                IC_REQ: begin
                    state <= IC_WAIT;
                end
                IC_WAIT: begin
                    if (MemDataReady_i) begin
                        // Invalidate as soon as the line starts changing so a
                        // partial block can never look like a hit
                        if (beatCnt == '0) begin
                            validArr[fillIdx] <= 1'b0;
                        end
                        if (lastBeat) begin
                            validArr[fillIdx] <= 1'b1;
                            beatCnt           <= '0;
                            state             <= IC_IDLE;
                        end else begin
                            beatCnt <= beatCnt + BEAT_ONE;
                        end
                    end
                end
                default: begin
                    state <= IC_IDLE;
                end
            endcase
        end
    end

    // Refill target capture plus tag/data array writes (not reset)
    always_ff @(posedge clk) begin
        if (missIdle) begin
            fillTag <= addrTag;
            fillIdx <= addrIdx;
        end
        if (beatWrite) begin
            dataArr[fillIdx][beatCnt] <= MemDataIn_i;
            if (lastBeat) begin
                tagArr[fillIdx] <= fillTag;
            end
        end
    end

endmodule

// File: tb/tb_ucsbece154b_icache.sv
// Self-checking bench for the direct-mapped instruction cache: directed
// sequences, a vector table of hit/no-request cases, and a randomized run
// against a line-level cache model with a beat-serving memory.
module tb_ucsbece154b_icache;

    localparam int NSETS = 8;
    localparam int WPB   = 4;

    logic        clk;
    logic        reset;
    logic        ReadEnable_i;
    logic [31:0] ReadAddress_i;
    logic [31:0] Instruction_o;
    logic        Ready_o;
    logic        Busy_o;
    logic        MemReadRequest_o;
    logic [31:0] MemReadAddress_o;
    logic        MemDataReady_i;
    logic [31:0] MemDataIn_i;

    ucsbece154b_icache #(.NUM_SETS(NSETS), .WORDS_PER_BLOCK(WPB)) dut (
        .clk              (clk),
        .reset            (reset),
        .ReadEnable_i     (ReadEnable_i),
        .ReadAddress_i    (ReadAddress_i),
        .Instruction_o    (Instruction_o),
        .Ready_o          (Ready_o),
        .Busy_o           (Busy_o),
        .MemReadRequest_o (MemReadRequest_o),
        .MemReadAddress_o (MemReadAddress_o),
        .MemDataReady_i   (MemDataReady_i),
        .MemDataIn_i      (MemDataIn_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Observed outputs of the last cycle
    logic [31:0] obsInstr, obsReqAddr;
    logic        obsReady, obsBusy, obsReq;

    // Memory responder state
    int          memPending  = 0;
    int          beatIdx     = 0;
    int          beatsSent   = 0;
    int          memMaxBeats = 1000000;
    int          strayLeft   = 0;
    logic [31:0] memBase     = 32'b0;
    bit          gapOn       = 1'b0;
    bit          strayOn     = 1'b0;
    bit          lastReal    = 1'b0;

    typedef struct {
        bit          re;
        logic [31:0] addr;
        bit          expReady;
        bit          expBusy;
        logic [31:0] expInstr;
    } vec_t;
    vec_t vecs[8];

    // Reference model: per-line residency plus one outstanding refill
    bit          mValid [NSETS];
    logic [31:0] mBlk   [NSETS];
    bit          mActive, mReqDue;
    logic [31:0] mBase;
    int          mGot;

    logic [31:0] ra, a, eInstr, eReqAddr;
    bit          eReady, eBusy, eReq, hitE, doRst, got;
    int          busyN, reqN;

    function automatic logic [31:0] memData(input logic [31:0] addr);
        logic [31:0] w;
        w = {addr[31:2], 2'b00};
        if (w[31:4] == 28'h0001000) return 32'hA0 + {28'b0, w[3:2]};
        return (w * 32'h9E3779B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] blk(input logic [31:0] addr);
        return {addr[31:4], 4'b0};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock: drive memory, sample outputs at negedge, advance past posedge
    task automatic tick();
        bit realBeat;
        realBeat = (memPending > 0) && (beatsSent < memMaxBeats) &&
                   !(gapOn && ($urandom_range(0, 3) == 0));
        if (realBeat) begin
            MemDataReady_i = 1'b1;
            MemDataIn_i    = memData(memBase + 32'(beatIdx * 4));
        end else if (memPending == 0 &&
                     (strayLeft > 0 || (strayOn && $urandom_range(0, 3) == 0))) begin
            MemDataReady_i = 1'b1;
            MemDataIn_i    = $urandom;
            if (strayLeft > 0) strayLeft--;
        end else begin
            MemDataReady_i = 1'b0;
            MemDataIn_i    = $urandom;
        end
        @(negedge clk);
        obsInstr   = Instruction_o;
        obsReady   = Ready_o;
        obsBusy    = Busy_o;
        obsReq     = MemReadRequest_o;
        obsReqAddr = MemReadAddress_o;
        lastReal   = realBeat;
        if (realBeat) begin
            memPending--;
            beatIdx++;
            beatsSent++;
        end
        if (obsReq) begin
            memPending = WPB;
            memBase    = obsReqAddr;
            beatIdx    = 0;
            beatsSent  = 0;
        end
        @(posedge clk);
        #1;
    endtask

    // Miss on addr, then expect one request, 2+WPB busy cycles and a hit
    task automatic missSeq(input string nm, input logic [31:0] addr);
        int  bN, rN;
        bit  ok;
        logic [31:0] rAddr;
        bN = 1; rN = 0; ok = 1'b0; rAddr = 32'b0;
        ReadEnable_i  = 1'b1;
        ReadAddress_i = addr;
        tick();
        chk({nm, " miss busy"},  32'(obsBusy),  32'd1);
        chk({nm, " miss ready"}, 32'(obsReady), 32'd0);
        for (int i = 0; i < 30 && !ok; i++) begin
            tick();
            if (obsReady) ok = 1'b1;
            else begin
                if (obsBusy) bN++;
                if (obsReq) begin
                    rN++;
                    rAddr = obsReqAddr;
                end
            end
        end
        chk({nm, " reached hit"},   32'(ok), 32'd1);
        chk({nm, " busy cycles"},   32'(bN), 32'(2 + WPB));
        chk({nm, " request count"}, 32'(rN), 32'd1);
        chk({nm, " request addr"},  rAddr, blk(addr));
        chk({nm, " instr"},         obsInstr, memData(addr));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 32'h00010000, 1'b1, 1'b0, 32'hA0};
        vecs[1] = '{1'b1, 32'h00010008, 1'b1, 1'b0, 32'hA2};
        vecs[2] = '{1'b1, 32'h0001000C, 1'b1, 1'b0, 32'hA3};
        vecs[3] = '{1'b1, 32'h00010007, 1'b1, 1'b0, 32'hA1};
        vecs[4] = '{1'b0, 32'h00010000, 1'b0, 1'b0, 32'h0};
        vecs[5] = '{1'b0, 32'h00050000, 1'b0, 1'b0, 32'h0};
        vecs[6] = '{1'b0, 32'h00050000, 1'b0, 1'b0, 32'h0};
        vecs[7] = '{1'b1, 32'h00010004, 1'b1, 1'b0, 32'hA1};

        reset          = 1'b1;
        ReadEnable_i   = 1'b0;
        ReadAddress_i  = 32'b0;
        MemDataReady_i = 1'b0;
        MemDataIn_i    = 32'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        tick();
        chk("reset ready",   32'(obsReady), 32'd0);
        chk("reset busy",    32'(obsBusy),  32'd0);
        chk("reset req",     32'(obsReq),   32'd0);
        chk("reset instr",   obsInstr,      32'd0);
        chk("reset reqaddr", obsReqAddr,    32'd0);

        // Cold miss
        missSeq("cold", 32'h00010004);
        chk("cold instr A1", obsInstr, 32'hA1);

        // Hit and no-request vectors
        for (int i = 0; i < 8; i++) begin
            ReadEnable_i  = vecs[i].re;
            ReadAddress_i = vecs[i].addr;
            tick();
            chk($sformatf("vec%0d ready", i), 32'(obsReady), 32'(vecs[i].expReady));
            chk($sformatf("vec%0d busy", i),  32'(obsBusy),  32'(vecs[i].expBusy));
            chk($sformatf("vec%0d instr", i), obsInstr,      vecs[i].expInstr);
            chk($sformatf("vec%0d req", i),   32'(obsReq),   32'd0);
        end

        // Conflict eviction and re-miss of the evicted block
        missSeq("conflict", 32'h00010084);
        missSeq("reload",   32'h00010004);

        // Redirect in the middle of a refill
        ReadEnable_i  = 1'b1;
        ReadAddress_i = 32'h00010080;
        tick();
        chk("redir miss busy", 32'(obsBusy), 32'd1);
        tick();
        chk("redir req",      32'(obsReq), 32'd1);
        chk("redir req addr", obsReqAddr,  32'h00010080);
        tick();
        ReadAddress_i = 32'h00020000;
        for (int i = 0; i < WPB - 1; i++) begin
            tick();
            chk($sformatf("redir wait%0d busy", i),  32'(obsBusy),  32'd1);
            chk($sformatf("redir wait%0d ready", i), 32'(obsReady), 32'd0);
            chk($sformatf("redir wait%0d req", i),   32'(obsReq),   32'd0);
        end
        tick();
        chk("redir new miss busy",  32'(obsBusy),  32'd1);
        chk("redir new miss ready", 32'(obsReady), 32'd0);
        chk("redir new miss req",   32'(obsReq),   32'd0);
        tick();
        chk("redir new req",      32'(obsReq), 32'd1);
        chk("redir new req addr", obsReqAddr,  32'h00020000);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (obsReady) got = 1'b1;
        end
        chk("redir new hit",   32'(got), 32'd1);
        chk("redir new instr", obsInstr, memData(32'h00020000));

        // Reset after two of four beats, then stray beats
        memMaxBeats   = 2;
        ReadAddress_i = 32'h00010080;
        tick();
        tick();
        tick();
        tick();
        tick();
        chk("partial stall busy", 32'(obsBusy), 32'd1);
        reset = 1'b1;
        tick();
        reset        = 1'b0;
        ReadEnable_i = 1'b0;
        memPending   = 0;
        memMaxBeats  = 1000000;
        strayLeft    = 2;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("post-reset%0d ready", i),   32'(obsReady), 32'd0);
            chk($sformatf("post-reset%0d busy", i),    32'(obsBusy),  32'd0);
            chk($sformatf("post-reset%0d req", i),     32'(obsReq),   32'd0);
            chk($sformatf("post-reset%0d instr", i),   obsInstr,      32'd0);
            chk($sformatf("post-reset%0d reqaddr", i), obsReqAddr,    32'd0);
        end
        missSeq("refetch", 32'h00010080);

        // Randomized run against the reference model
        reset        = 1'b1;
        ReadEnable_i = 1'b0;
        tick();
        reset      = 1'b0;
        memPending = 0;
        for (int s = 0; s < NSETS; s++) mValid[s] = 1'b0;
        mActive = 1'b0;
        mReqDue = 1'b0;
        mGot    = 0;
        mBase   = 32'b0;
        gapOn   = 1'b1;
        strayOn = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            a = (($urandom_range(0, 1) == 1) ? 32'h00030000 : 32'h00040000)
                | (32'($urandom_range(0, 3)) << 4)
                | (32'($urandom_range(0, 3)) << 2)
                | 32'($urandom_range(0, 3));
            doRst         = ($urandom_range(0, 127) == 0);
            ReadAddress_i = a;
            ReadEnable_i  = ($urandom_range(0, 7) != 0);
            if (doRst) begin
                reset = 1'b1;
                tick();
                reset      = 1'b0;
                memPending = 0;
                for (int s = 0; s < NSETS; s++) mValid[s] = 1'b0;
                mActive = 1'b0;
                mReqDue = 1'b0;
                continue;
            end
            if (!mActive) begin
                hitE     = ReadEnable_i && mValid[a[6:4]] && (mBlk[a[6:4]] == blk(a));
                eReady   = hitE;
                eBusy    = ReadEnable_i && !hitE;
                eReq     = 1'b0;
                eReqAddr = 32'b0;
                eInstr   = hitE ? memData(a) : 32'b0;
            end else begin
                eReady   = 1'b0;
                eBusy    = 1'b1;
                eReq     = mReqDue;
                eReqAddr = mReqDue ? mBase : 32'b0;
                eInstr   = 32'b0;
            end
            tick();
            chk($sformatf("rnd%0d ready", c),   32'(obsReady), 32'(eReady));
            chk($sformatf("rnd%0d busy", c),    32'(obsBusy),  32'(eBusy));
            chk($sformatf("rnd%0d req", c),     32'(obsReq),   32'(eReq));
            chk($sformatf("rnd%0d reqaddr", c), obsReqAddr,    eReqAddr);
            chk($sformatf("rnd%0d instr", c),   obsInstr,      eInstr);
            if (!mActive) begin
                if (eBusy) begin
                    mActive          = 1'b1;
                    mReqDue          = 1'b1;
                    mBase            = blk(a);
                    mGot             = 0;
                    mValid[a[6:4]]   = 1'b0;
                end
            end else if (mReqDue) begin
                mReqDue = 1'b0;
            end else if (lastReal) begin
                mGot++;
                if (mGot == WPB) begin
                    mActive            = 1'b0;
                    mValid[mBase[6:4]] = 1'b1;
                    mBlk[mBase[6:4]]   = mBase;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
